stream_scaler_nn: RTL

- Streaming nearest-neighbour video scaler with independent up- and down-scaling on each axis.
- Accepts one raster-ordered source frame on a valid/ready input and stores one source row at a time in an internal line buffer.
- Emits the destination frame on a valid/ready output, with start-of-line, end-of-line and end-of-frame markers.
- Parametrised successor of the fixed 640-wide, fixed-16-bit scaler path. Sits between the input frame FIFO and the DDR3 write arbiter.

---
 rtl/stream_scaler_nn_if.sv | 24 ++
 rtl/stream_scaler_nn.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/stream_scaler_nn_if.sv
// rtl/stream_scaler_nn_if.sv - Source and destination pixel stream bundle for stream_scaler_nn.
interface stream_scaler_nn_if #(
  parameter int PIX_WIDTH = 16
);
  logic                 s_valid;
  logic [PIX_WIDTH-1:0] s_data;
  logic                 s_ready;
  logic                 m_valid;
  logic [PIX_WIDTH-1:0] m_data;
  logic                 m_sol;
  logic                 m_eol;
  logic                 m_eof;
  logic                 m_ready;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_sol, m_eol, m_eof
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_sol, m_eol, m_eof
  );
endinterface

// File: rtl/stream_scaler_nn.sv
// rtl/stream_scaler_nn.sv - Nearest-neighbour stream scaler with a one-row line buffer.
// Optional horizontal mirroring is built when SCALER_MIRROR_EN is defined.
module stream_scaler_nn #(
  parameter int PIX_WIDTH = 16,
  parameter int FRAC_BITS = 11,
  parameter int STEP_W    = 15,
  parameter int MAX_H     = 2048,
  parameter int DIM_W     = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [DIM_W-1:0]  src_h,
  input  logic [DIM_W-1:0]  src_v,
  input  logic [DIM_W-1:0]  dst_h,
  input  logic [DIM_W-1:0]  dst_v,
  input  logic [STEP_W-1:0] x_step,
  input  logic [STEP_W-1:0] y_step,
  input  logic              mirror_en,
  stream_scaler_nn_if.slave strm,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);
  localparam int ACC_W = DIM_W + FRAC_BITS;
  localparam int AW    = $clog2(MAX_H);
  localparam int CNT_W = 2 * DIM_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_DRAIN} state_t;
  state_t r_state, w_next;

  logic [DIM_W-1:0]     r_src_h, r_src_v, r_dst_h, r_dst_v;
  logic [STEP_W-1:0]    r_x_step, r_y_step;
  logic [CNT_W-1:0]     r_total, r_in_cnt;
  logic [DIM_W-1:0]     r_col, r_src_row, r_dst_row, r_issue_col, r_p1_col;
  logic [ACC_W-1:0]     r_x_acc, r_y_acc;
  logic                 r_p1_vld;
  logic [AW-1:0]        r_rd_addr;
  logic [PIX_WIDTH-1:0] r_ram_q;
  logic [PIX_WIDTH-1:0] r_mem [MAX_H];
  logic                 r_m_valid, r_m_sol, r_m_eol, r_m_eof;
  logic [PIX_WIDTH-1:0] r_m_data;
  logic                 r_busy, r_done, r_cfg_err;

  logic                 w_cfg_ok, w_cfg_go, w_s_ready, w_s_fire, w_row_last;
  logic                 w_adv, w_m_last, w_last_dst, w_drain_done, w_issue;
  logic [ACC_W-1:0]     w_y_next;
  logic [DIM_W-1:0]     w_row_idx, w_next_idx, w_x_idx, w_col, w_col_m;
  logic [AW-1:0]        w_rd_addr;
  logic                 w_unused;

  assign w_cfg_ok = (src_h != '0) && (src_v != '0) && (dst_h != '0) && (dst_v != '0) &&
                    (x_step != '0) && (y_step != '0) && (src_h <= DIM_W'(MAX_H));
  assign w_cfg_go = cfg_start && (r_state == S_IDLE) && w_cfg_ok;

  // DRAIN stops accepting once the frame's pixel count is reached so the next frame is untouched
  assign w_s_ready    = (r_state == S_LOAD) || ((r_state == S_DRAIN) && (r_in_cnt != r_total));
  assign w_s_fire     = strm.s_valid && w_s_ready;
  assign w_row_last   = (r_col == r_src_h - DIM_W'(1));
  assign w_drain_done = (r_in_cnt == r_total) || (w_s_fire && (r_in_cnt + CNT_W'(1) == r_total));

  assign w_adv      = !r_m_valid || strm.m_ready;
  assign w_m_last   = r_m_valid && strm.m_ready && r_m_eol;
  assign w_y_next   = r_y_acc + ACC_W'(r_y_step);
  assign w_row_idx  = r_y_acc[ACC_W-1:FRAC_BITS];
  assign w_next_idx = w_y_next[ACC_W-1:FRAC_BITS];
  assign w_last_dst = (r_dst_row + DIM_W'(1) == r_dst_v);
  assign w_issue    = (r_state == S_EMIT) && (r_issue_col < r_dst_h);

  assign w_x_idx = r_x_acc[ACC_W-1:FRAC_BITS];
  assign w_col   = (w_x_idx > r_src_h - DIM_W'(1)) ? r_src_h - DIM_W'(1) : w_x_idx;

`ifdef SCALER_MIRROR_EN
  logic r_mirror;
  always_ff @(posedge clk) begin
    if (rst)           r_mirror <= 1'b0;
    else if (w_cfg_go) r_mirror <= mirror_en;
  end
  assign w_col_m  = r_mirror ? (r_src_h - DIM_W'(1) - w_col) : w_col;
  assign w_unused = ^w_col_m[DIM_W-1:AW];
`else
  assign w_col_m  = w_col;
  assign w_unused = ^{mirror_en, w_col_m[DIM_W-1:AW]};
`endif

  // On a stall the RAM re-reads the address of the pixel it already holds
  assign w_rd_addr = w_adv ? w_col_m[AW-1:0] : r_rd_addr;

  always_ff @(posedge clk) begin
    if (w_s_fire && (r_state == S_LOAD)) r_mem[r_col[AW-1:0]] <= strm.s_data;
    r_ram_q <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_cfg_go) w_next = S_LOAD;
      S_LOAD:  if (w_s_fire && w_row_last && (w_row_idx == r_src_row)) w_next = S_EMIT;
      S_EMIT: begin
        if (w_m_last) begin
          if (w_last_dst)                    w_next = S_DRAIN;
          else if (w_next_idx != r_src_row)  w_next = S_LOAD;
        end
      end
      S_DRAIN: if (w_drain_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_h <= '0; r_src_v <= '0; r_dst_h <= '0; r_dst_v <= '0;
      r_x_step <= '0; r_y_step <= '0; r_total <= '0; r_in_cnt <= '0;
      r_col <= '0; r_src_row <= '0; r_dst_row <= '0; r_issue_col <= '0; r_p1_col <= '0;
      r_x_acc <= '0; r_y_acc <= '0; r_p1_vld <= 1'b0; r_rd_addr <= '0;
      r_m_valid <= 1'b0; r_m_data <= '0; r_m_sol <= 1'b0; r_m_eol <= 1'b0; r_m_eof <= 1'b0;
      r_busy <= 1'b0; r_done <= 1'b0; r_cfg_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= cfg_start && (r_state == S_IDLE) && !w_cfg_ok;
      if (w_cfg_go) begin
        r_src_h <= src_h; r_src_v <= src_v; r_dst_h <= dst_h; r_dst_v <= dst_v;
        r_x_step <= x_step; r_y_step <= y_step;
        r_total <= CNT_W'(src_v) * CNT_W'(src_h);
        r_in_cnt <= '0; r_col <= '0; r_src_row <= '0; r_dst_row <= '0;
        r_issue_col <= '0; r_x_acc <= '0; r_y_acc <= '0;
        r_busy <= 1'b1;
      end
      if (w_s_fire) begin
        r_in_cnt <= r_in_cnt + CNT_W'(1);
        if (r_state == S_LOAD) begin
          r_col <= w_row_last ? '0 : r_col + DIM_W'(1);
          if (w_row_last && (w_row_idx != r_src_row)) r_src_row <= r_src_row + DIM_W'(1);
        end
      end
      if (w_m_last) begin
        r_y_acc     <= w_y_next;
        r_dst_row   <= r_dst_row + DIM_W'(1);
        r_issue_col <= '0;
        r_x_acc     <= '0;
        if (!w_last_dst && (w_next_idx != r_src_row)) r_src_row <= r_src_row + DIM_W'(1);
      end else if (w_adv) begin
        r_p1_vld <= w_issue;
        if (w_issue) begin
          r_p1_col    <= r_issue_col;
          r_rd_addr   <= w_rd_addr;
          r_x_acc     <= r_x_acc + ACC_W'(r_x_step);
          r_issue_col <= r_issue_col + DIM_W'(1);
        end
      end
      if (w_adv) begin
        r_m_valid <= r_p1_vld;
        r_m_sol   <= r_p1_vld && (r_p1_col == '0);
        r_m_eol   <= r_p1_vld && (r_p1_col == r_dst_h - DIM_W'(1));
        r_m_eof   <= r_p1_vld && (r_p1_col == r_dst_h - DIM_W'(1)) &&
                     (r_dst_row == r_dst_v - DIM_W'(1));
        if (r_p1_vld) r_m_data <= r_ram_q;
      end
      if ((r_state == S_DRAIN) && w_drain_done) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign strm.s_ready = w_s_ready;
  assign strm.m_valid = r_m_valid;
  assign strm.m_data  = r_m_data;
  assign strm.m_sol   = r_m_sol;
  assign strm.m_eol   = r_m_eol;
  assign strm.m_eof   = r_m_eof;
  assign busy         = r_busy;
  assign done         = r_done;
  assign cfg_err      = r_cfg_err;
endmodule
